// File: rtl/stopwatch_counter.sv
// Six-digit BCD stopwatch time base (mm:ss.cc) with an internal centisecond prescaler.
// Optional lap capture register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        load,
  input  logic [23:0] load_value,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic [23:0] lap_time,
`endif
  output logic [23:0] count,
  output logic        tick,
  output logic        wrap
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0] ps;
  logic [23:0]     load_clean;
  logic [23:0]     count_inc;
  logic            inc_carry;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? 4'd0 : d;
  endfunction

  always_comb begin
    load_clean = {clamp_digit(load_value[23:20], 4'd5),
                  clamp_digit(load_value[19:16], 4'd9),
                  clamp_digit(load_value[15:12], 4'd5),
                  clamp_digit(load_value[11:8],  4'd9),
                  clamp_digit(load_value[7:4],   4'd9),
                  clamp_digit(load_value[3:0],   4'd9)};
  end

  // Ripple-carry BCD increment; digit 3 (sec tens) and 5 (min tens) roll at 5.
  // Carry out of the top digit is exactly the 59:59.99 -> 00:00.00 wrap.
  always_comb begin
    logic [3:0] lim;
    count_inc = count;
    inc_carry = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (inc_carry) begin
        if (count[4*i +: 4] == lim) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      ps    <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clean;
      ps    <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (EN) begin
      if (ps == PS_LAST) begin
        ps    <= '0;
        count <= count_inc;
        tick  <= 1'b1;
        wrap  <= inc_carry;
      end else begin
        ps    <= ps + 1'b1;
        tick  <= 1'b0;
        wrap  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Captures the pre-update count, so a lap coincident with load sees the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_time <= '0;
    end else if (lap) begin
      lap_time <= count;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter at DIV=10: centisecond-integer reference model
// compared every cycle, plus directed literal checks.
module tb_stopwatch_counter;

  localparam int DIV = 10;
  localparam int FULL = 360000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EN = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_value = '0;
  logic [23:0] count;
  logic        tick;
  logic        wrap;
`ifdef STOPWATCH_LAP_EN
  logic        lap = 1'b0;
  logic [23:0] lap_time;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .load      (load),
    .load_value(load_value),
`ifdef STOPWATCH_LAP_EN
    .lap       (lap),
    .lap_time  (lap_time),
`endif
    .count     (count),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: time held as a plain centisecond integer.
  int          m_t = 0;
  int          m_ps = 0;
  logic        m_tick = 1'b0;
  logic        m_wrap = 1'b0;
  logic [23:0] m_lap = '0;

  function automatic logic [23:0] to_bcd(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int from_load(input logic [23:0] v);
    int d[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (d[i] > (((i == 3) || (i == 5)) ? 5 : 9)) d[i] = 0;
    end
    return (d[5] * 10 + d[4]) * 6000 + (d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_t = 0; m_ps = 0; m_tick = 1'b0; m_wrap = 1'b0; m_lap = '0;
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (lap) m_lap = to_bcd(m_t);
`endif
      m_tick = 1'b0;
      m_wrap = 1'b0;
      if (load) begin
        m_t = from_load(load_value);
        m_ps = 0;
      end else if (EN) begin
        if (m_ps == DIV - 1) begin
          m_ps = 0;
          m_tick = 1'b1;
          m_wrap = (m_t == FULL - 1);
          m_t = (m_t + 1) % FULL;
        end else begin
          m_ps = m_ps + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", count, to_bcd(m_t));
      chk("model_tick", {23'd0, tick}, {23'd0, m_tick});
      chk("model_wrap", {23'd0, wrap}, {23'd0, m_wrap});
`ifdef STOPWATCH_LAP_EN
      chk("model_lap", lap_time, m_lap);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int first_tick, last_tick, n_ticks, resume_tick;

  initial begin
    // Reset with EN and load asserted: reset must win.
    @(negedge clk);
    rst = 1'b0; EN = 1'b1; load = 1'b1; load_value = 24'h123456;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    chk("reset_count", count, 24'h000000);
    chk("reset_tick", {23'd0, tick}, 24'd0);
    chk("reset_wrap", {23'd0, wrap}, 24'd0);

    // Run 100 cycles from reset release.
    rst = 1'b1; load = 1'b0; EN = 1'b1;
    first_tick = 0; last_tick = 0; n_ticks = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (tick === 1'b1) begin
        if (n_ticks == 0) first_tick = i;
        last_tick = i;
        n_ticks++;
      end
    end
    chk("run_count", count, 24'h000010);
    chk("run_first_tick", 24'(first_tick), 24'd10);
    chk("run_n_ticks", 24'(n_ticks), 24'd10);
    chk("run_last_tick", 24'(last_tick), 24'd100);

    // Pause keeps the partial prescale.
    rst = 1'b0; EN = 1'b0;
    cyc(1);
    rst = 1'b1; EN = 1'b1;
    cyc(15);
    EN = 1'b0;
    cyc(20);
    chk("pause_hold", count, 24'h000001);
    EN = 1'b1;
    resume_tick = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      if (tick === 1'b1 && resume_tick == 0) resume_tick = i;
    end
    chk("pause_count", count, 24'h000002);
    chk("pause_resume_tick", 24'(resume_tick), 24'd5);

    // Wrap through 59:59.99; EN high during load must be ignored.
    load = 1'b1; load_value = 24'h595998; EN = 1'b1;
    cyc(1);
    chk("wrap_loaded", count, 24'h595998);
    load = 1'b0;
    cyc(10);
    chk("wrap_pre", count, 24'h595999);
    cyc(10);
    chk("wrap_zero", count, 24'h000000);
    chk("wrap_pulse", {23'd0, wrap}, 24'd1);
    cyc(1);
    chk("wrap_one_cycle", {23'd0, wrap}, 24'd0);
    cyc(9);
    chk("wrap_after", count, 24'h000001);

    // Sanitize on load.
    EN = 1'b0; load = 1'b1; load_value = 24'h6A7B9C;
    cyc(1);
    chk("sanitize", count, 24'h000090);
    load = 1'b0;

    // Reset mid-tick aborts the partial prescale.
    EN = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(9);
    chk("midrst_no_tick", count, 24'h000000);
    cyc(1);
    chk("midrst_tick", count, 24'h000001);

    // EN falling on the terminal prescale edge suppresses the increment.
    cyc(9);
    EN = 1'b0;
    cyc(3);
    chk("en_fall_terminal", count, 24'h000001);
    EN = 1'b1;
    cyc(1);
    chk("en_resume_terminal", count, 24'h000002);

`ifdef STOPWATCH_LAP_EN
    EN = 1'b0; load = 1'b1; load_value = 24'h000123;
    cyc(1);
    load = 1'b0; EN = 1'b1; lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap_capture", lap_time, 24'h000123);
    cyc(9);
    chk("lap_count_runs", count, 24'h000124);
    lap = 1'b1; load = 1'b1; load_value = 24'h000500;
    cyc(1);
    lap = 1'b0; load = 1'b0;
    chk("lap_with_load", lap_time, 24'h000124);
    chk("lap_load_count", count, 24'h000500);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    chk("lap_reset", lap_time, 24'h000000);
`endif

    cyc(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Six-digit BCD stopwatch time base (mm:ss.cc) that consumes the `rst`, `EN` and `load` controls produced by the key control stage and drives the display path. An internal prescaler derives a centisecond tick from the system clock. The block counts 00:00.00 to 59:59.99 and wraps. A synchronous load presets the count from a BCD value.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 100: count rate. Prescaler divisor DIV = CLK_HZ/TICK_HZ. CLK_HZ must divide exactly and DIV must be at least 2.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-low reset, driven by the key control `rst` output.
- `EN` input 1: count enable. High means counting; low means paused.
- `load` input 1: synchronous preset, level-sensitive.
- `load_value` input 24: BCD preset, same layout as `count`.
- `count` output 24: [23:20] min tens 0–5, [19:16] min units 0–9, [15:12] sec tens 0–5, [11:8] sec units 0–9, [7:4] cs tens 0–9, [3:0] cs units 0–9.
- `tick` output 1: one-cycle pulse, high in the cycle `count` shows an incremented value.
- `wrap` output 1: one-cycle pulse, high in the cycle `count` rolls 59:59.99 → 00:00.00.
- `lap` input 1: lap capture strobe. Present only with `STOPWATCH_LAP_EN`.
- `lap_time` output 24: captured count. Present only with `STOPWATCH_LAP_EN`.

## Operation
- Priority: `rst`=0, then `load`=1, then increment.
- Reset (`rst`=0 at a rising edge): `count`=0x000000, prescaler `ps`=0, `tick`=0, `wrap`=0, `lap_time`=0x000000.
- Load (`load`=1, `rst`=1):
  - `count` takes the sanitized `load_value`; `ps`=0.
  - `tick`=0, `wrap`=0.
  - `EN` is ignored while `load` is held.
- Sanitize rule, applied per digit: any units or cs-tens digit above 9 becomes 0; any min-tens or sec-tens digit above 5 becomes 0.
- Prescaler:
  - When `EN`=1, `ps` increments; at `ps`=DIV-1 it returns to 0 and an increment occurs.
  - When `EN`=0, `ps` holds. Pause and resume therefore keep the partial tick; no time is lost or gained.
- Increment is a ripple-carry BCD chain:
  - cs units 9→0 carries into cs tens; cs tens 9→0 carries into sec units.
  - sec units 9→0 carries; sec tens 5→0 carries.
  - min units 9→0 carries; min tens 5→0 wraps the whole count to 0x000000 and asserts `wrap`.
- No state machine beyond the prescaler; the run/stop/reset sequencing is owned by the key control stage.
- Holding `rst` low has the same effect as STOP/clear. When `rst` releases with `EN`=1, counting starts from `ps`=0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Increment latency: in the edge where `EN`=1 and `ps`=DIV-1, `count`+1 and `tick`=1 are both registered, so they are visible together in the following cycle.
- With `EN` held high from reset release, the first `tick` follows the DIV-th active edge. After that, `tick` repeats every DIV cycles.
- `wrap` is coincident with the `tick` that shows 0x000000 after 0x595999.
- `load` takes effect on the next edge. The first increment after `load` falls comes DIV enabled cycles later.
- `rst` low mid-tick aborts the partial prescale.
- Simultaneous `EN` fall and terminal `ps`: the increment is suppressed, because `EN` is sampled in the same edge.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - The `lap` and `lap_time` ports exist.
  - A `lap`=1 sample copies the current `count` (its value before this edge's update) into `lap_time`, and `count` keeps running.
  - If `lap` and `load` occur in the same cycle, the pre-load count is captured.
  - `rst`=0 clears `lap_time`.
- Not defined: the `lap` and `lap_time` ports are absent, and no capture register is built.

## Test plan
- Reset: `rst`=0 for 2 cycles with `EN`=1, `load`=1 → `count`=0x000000, `tick`=0, `wrap`=0.
- Run, with CLK_HZ=1000, TICK_HZ=100 (DIV=10): `EN`=1 for 100 cycles → `count`=0x000010; the first `tick` comes 10 cycles after release, then one every 10 cycles.
- Pause, DIV=10: `EN`=1 for 15 cycles, then `EN`=0 for 20 cycles, then `EN`=1 for 5 cycles → `count`=0x000002; the second `tick` arrives exactly 5 cycles after resume.
- Wrap: `load`=1 with `load_value`=0x595998 for 1 cycle, then `EN`=1 for 20 cycles → `count` reads 0x595999, then 0x000000 with a single-cycle `wrap`, then 0x000001.
- Sanitize: `load_value`=0x6A7B9C → `count`=0x000090.
- Lap (macro on): `lap` pulse while `count`=0x000123 → `lap_time`=0x000123 and `count` keeps advancing. Macro off: the design elaborates without the `lap` and `lap_time` ports.
